input_conditioner: RTL

Conditions a raw, asynchronous single-bit input into a clean, clock-aligned level for the edge and pulse detection stages directly downstream. It synchronizes the input through a flop chain and debounces it with a stable-count state machine. It emits the filtered level, one-cycle rise/fall strobes and a saturating count of rejected glitches. The `level` output is the intended `a` input of the downstream posedge and one-cycle-pulse detectors.

---
 rtl/input_conditioner.sv | 109 ++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronize and debounce a raw asynchronous input into a clean level.
// Ports:
//   clk          - single clock, all state updates on posedge
//   rst          - synchronous active-high reset
//   a            - raw input, may be asynchronous to clk
//   level        - debounced level (registered)
//   rise, fall   - one-cycle strobes in the first cycle level changes to 1 / to 0
//   settling     - 1 while a candidate level change is being qualified
//   glitch_count - saturating count of aborted candidate changes
module input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_count
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic s, glitch, level_n;

    assign s = sync[SYNC_STAGES-1];
    assign level_n = (state_n == HIGH) || (state_n == WAIT_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= '0;
            state        <= LOW;
            cnt          <= '0;
            level        <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            settling     <= 1'b0;
            glitch_count <= '0;
        end else begin
            // The cast drops the oldest stage; works for a single-stage chain too.
            sync     <= SYNC_STAGES'({sync, a});
            state    <= state_n;
            cnt      <= cnt_n;
            level    <= level_n;
            rise     <= level_n & ~level;
            fall     <= ~level_n & level;
            settling <= (state_n == WAIT_HIGH) || (state_n == WAIT_LOW);
            if (glitch && !(&glitch_count))
                glitch_count <= glitch_count + GLITCH_W'(1);
        end
    end

    // cnt holds how many consecutive candidate samples have already been seen;
    // the sample that makes it STABLE_CYCLES commits the new level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        glitch  = 1'b0;
        case (state)
            LOW: if (s) begin
                if (STABLE_CYCLES == 1) state_n = HIGH;
                else begin
                    state_n = WAIT_HIGH;
                    cnt_n   = ONE;
                end
            end
            WAIT_HIGH: if (s) begin
                if (cnt == LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else cnt_n = cnt + ONE;
            end else begin
                state_n = LOW;
                cnt_n   = '0;
                glitch  = 1'b1;
            end
            HIGH: if (!s) begin
                if (STABLE_CYCLES == 1) state_n = LOW;
                else begin
                    state_n = WAIT_LOW;
                    cnt_n   = ONE;
                end
            end
            WAIT_LOW: if (!s) begin
                if (cnt == LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else cnt_n = cnt + ONE;
            end else begin
                state_n = HIGH;
                cnt_n   = '0;
                glitch  = 1'b1;
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end
endmodule
